fir_decim: RTL and testbench

Streaming decimating FIR filter core for the FM radio chain. It pops signed fixed-point samples from a first-word-fall-through input FIFO and filters them through a TAPS-deep delay line. On every DECIM-th input sample it runs a sequential multiply-accumulate and pushes one filtered sample into an output FIFO. It sits between the FIFO pairs inside the filter top-level, on the far side of the FIFO interfaces the stream source and sink drive.

---
 rtl/fir_decim_pkg.sv | 31 +++
 rtl/fir_decim.sv | 112 +++++++++++
 tb/tb_fir_decim.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg: shared constants, state encoding and helpers for the
// decimating FIR core. Coefficients and samples are signed Q10.
// Contents: QUANT_BITS, DEFAULT_COEFFS, state_t, dequantize().
package fir_decim_pkg;

  localparam int QUANT_BITS   = 10;
  localparam int DEFAULT_TAPS = 32;
  // dequantize() works on a fixed wide container so it serves any
  // DATA_WIDTH up to 64; callers truncate the result to their width.
  localparam int DEQ_W        = 128;

  // Symmetric low-pass prototype, Q10 (1024 = 1.0).
  localparam logic signed [31:0] DEFAULT_COEFFS [0:DEFAULT_TAPS-1] = '{
    -3,  -5,  -6,  -4,   0,   8,  18,  30,
    42,  55,  66,  75,  82,  87,  90,  91,
    91,  90,  87,  82,  75,  66,  55,  42,
    30,  18,   8,   0,  -4,  -6,  -5,  -3
  };

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Remove the Q10 scaling of a product: arithmetic shift, rounds to -inf.
  function automatic logic signed [DEQ_W-1:0] dequantize(input logic signed [DEQ_W-1:0] p);
    return p >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/fir_decim.sv
// fir_decim: decimating FIR core between an input FWFT FIFO and an output FIFO.
// Ports: clock/reset (sync, active-high); in_empty/in_rd_en/in_dout pop side;
//        out_full/out_wr_en/out_din push side. One output per DECIM pops,
//        TAPS MAC cycles then a write cycle that holds while out_full is high.
module fir_decim
  import fir_decim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 32,
  parameter int DECIM      = 8,
  parameter logic signed [31:0] COEFFS [0:TAPS-1] = DEFAULT_COEFFS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int KW = (TAPS  > 1) ? $clog2(TAPS)  : 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0]   x [TAPS];
  logic signed [DATA_WIDTH-1:0]   acc;
  logic [KW-1:0]                  k;
  logic [CW-1:0]                  decim_cnt;

  logic                           last_pop;
  logic                           last_tap;
  logic signed [DATA_WIDTH-1:0]   x_k;
  logic signed [DATA_WIDTH-1:0]   h_k;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   deq;

  assign last_pop = (decim_cnt == CW'(DECIM - 1));
  assign last_tap = (k == KW'(TAPS - 1));

  // Single shared multiplier: full-width product, then per-product
  // dequantize and truncation back to the accumulator width.
  assign x_k  = x[k];
  assign h_k  = DATA_WIDTH'(COEFFS[k]);
  assign prod = (2*DATA_WIDTH)'(x_k) * (2*DATA_WIDTH)'(h_k);
  assign deq  = DATA_WIDTH'(dequantize(DEQ_W'(prod)));

  assign out_din = acc;

  always_ff @(posedge clock) begin
    if (reset) state <= S_READ;
    else       state <= state_nxt;
  end

  // Handshakes are forced low during reset so nothing is popped or pushed
  // while the core is being cleared.
  always_comb begin
    state_nxt = state;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (!reset) begin
      case (state)
        S_READ: begin
          in_rd_en = !in_empty;
          if (!in_empty && last_pop) state_nxt = S_MAC;
        end
        S_MAC: begin
          if (last_tap) state_nxt = S_WRITE;
        end
        S_WRITE: begin
          out_wr_en = !out_full;
          if (!out_full) state_nxt = S_READ;
        end
        default: state_nxt = S_READ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      acc       <= '0;
      k         <= '0;
      decim_cnt <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (in_rd_en) begin
            x[0] <= in_dout;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            if (last_pop) begin
              decim_cnt <= '0;
              acc       <= '0;
              k         <= '0;
            end else begin
              decim_cnt <= decim_cnt + CW'(1);
            end
          end
        end
        S_MAC: begin
          // Accumulator wraps on overflow by construction.
          acc <= acc + deq;
          if (!last_tap) k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
module tb_fir_decim;

  localparam int DW    = 32;
  localparam int TAPS  = 32;
  localparam int DECIM = 8;
  localparam int BP_CYC = 100;

  logic          clock;
  logic          reset;
  logic          in_empty;
  logic          in_rd_en;
  logic [DW-1:0] in_dout;
  logic          out_full;
  logic          out_wr_en;
  logic [DW-1:0] out_din;

  fir_decim #(.DATA_WIDTH(DW), .TAPS(TAPS), .DECIM(DECIM)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .in_dout   (in_dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .out_din   (out_din)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind: 0 impulse, 1 DC, 2 negative impulse, 3 random
  // mode: 0 free-flowing, 1 back-pressure in write, 2 starvation, 3 random stalls
  typedef struct packed {
    logic [1:0]       kind;
    logic [1:0]       mode;
    logic [7:0][31:0] exp;
  } vec_t;

  vec_t tbl [5];

  int H [TAPS];
  int hist [TAPS];
  int dcnt;
  int wait_cnt;
  int mode;
  bit starve_ph;
  int src_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: y = sum over taps of floor(x*h / 1024), truncated to 32 bits.
  function automatic int model_y();
    int s = 0;
    for (int i = 0; i < TAPS; i++) begin
      longint p = longint'(hist[i]) * longint'(H[i]);
      s += int'(p >>> 10);
    end
    return s;
  endfunction

  task automatic set_inputs();
    int nxt;
    nxt = (wait_cnt >= 0) ? wait_cnt + 1 : -1;
    starve_ph = ~starve_ph;
    in_empty = (src_q.size() == 0) || (mode == 2 && starve_ph) ||
               (mode == 3 && $urandom_range(0, 9) < 3);
    in_dout  = (src_q.size() != 0) ? src_q[0] : $urandom;
    out_full = (mode == 1 && nxt >= TAPS + 1 && nxt <= TAPS + BP_CYC) ||
               (mode == 3 && $urandom_range(0, 9) < 3);
  endtask

  task automatic step();
    logic pop, push;
    @(negedge clock);
    if (wait_cnt >= 0) wait_cnt++;
    pop  = in_rd_en & ~in_empty;
    push = out_wr_en & ~out_full;
    if (wait_cnt < 0) begin
      chk("read_rd_en", {31'd0, in_rd_en}, {31'd0, ~in_empty});
      chk("read_wr_en", {31'd0, out_wr_en}, 32'd0);
    end else if (wait_cnt <= TAPS) begin
      chk("mac_quiet", {30'd0, in_rd_en, out_wr_en}, 32'd0);
    end else begin
      chk("write_wr_en", {31'd0, out_wr_en}, {31'd0, ~out_full});
      chk("write_rd_en", {31'd0, in_rd_en}, 32'd0);
      if (exp_q.size() != 0) chk("write_din", out_din, exp_q[0]);
    end
    if (push) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_push", {31'd0, out_wr_en}, 32'd0);
      end else begin
        chk("push_data", out_din, exp_q.pop_front());
        got_q.push_back(out_din);
      end
      wait_cnt = -1;
    end
    @(posedge clock);
    #1;
    if (pop) begin
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = src_q.pop_front();
      dcnt++;
      if (dcnt == DECIM) begin
        dcnt = 0;
        exp_q.push_back(model_y());
        wait_cnt = 0;
      end
    end
    set_inputs();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_empty = 1'b0;
    in_dout  = 32'h1234;
    out_full = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("rst_din", out_din, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    dcnt = 0;
    wait_cnt = -1;
    mode = 0;
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    set_inputs();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || wait_cnt >= 0) && n < 6000) begin
      step();
      n++;
    end
    chk({nm, "_done"}, {31'd0, n < 6000}, 32'd1);
  endtask

  task automatic run_scn(input int idx, input bit rst);
    string nm;
    nm = $sformatf("scn%0d", idx);
    if (rst) do_reset();
    mode = int'(tbl[idx].mode);
    got_q.delete();
    for (int i = 0; i < 64; i++) begin
      case (tbl[idx].kind)
        2'd0:    src_q.push_back((i == 0) ? 1024 : 0);
        2'd1:    src_q.push_back(1024);
        default: src_q.push_back((i == 0) ? -1024 : 0);
      endcase
    end
    set_inputs();
    drain(nm);
    chk({nm, "_count"}, got_q.size(), 32'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < got_q.size()) chk($sformatf("%s_out%0d", nm, j), got_q[j], tbl[idx].exp[j]);
      else                  chk($sformatf("%s_out%0d", nm, j), 32'hxxxx_xxxx, tbl[idx].exp[j]);
    end
  endtask

  initial begin
    int n;
    int s;
    reset = 1'b1;
    in_empty = 1'b1;
    in_dout = '0;
    out_full = 1'b0;
    mode = 0;
    starve_ph = 1'b0;
    wait_cnt = -1;
    dcnt = 0;

    for (int i = 0; i < TAPS; i++) H[i] = int'(fir_decim_pkg::DEFAULT_COEFFS[i]);

    // Expected outputs straight from the coefficient table.
    for (int r = 0; r < 5; r++) tbl[r] = '0;
    tbl[0].kind = 2'd0; tbl[0].mode = 2'd0;
    tbl[1].kind = 2'd1; tbl[1].mode = 2'd0;
    tbl[2].kind = 2'd2; tbl[2].mode = 2'd0;
    tbl[3].kind = 2'd1; tbl[3].mode = 2'd1;
    tbl[4].kind = 2'd1; tbl[4].mode = 2'd2;
    for (int j = 0; j < 4; j++) begin
      tbl[0].exp[j] = H[8*j + 7];
      tbl[2].exp[j] = -H[8*j + 7];
    end
    for (int j = 0; j < 8; j++) begin
      s = 0;
      for (int i = 0; i < TAPS && i < 8*(j+1); i++) s += H[i];
      tbl[1].exp[j] = s;
      tbl[3].exp[j] = s;
      tbl[4].exp[j] = s;
    end

    do_reset();

    for (int r = 0; r < 5; r++) run_scn(r, 1'b1);

    // Reset in the middle of a MAC with a non-zero delay line.
    do_reset();
    for (int i = 0; i < DECIM; i++) src_q.push_back(1024);
    set_inputs();
    n = 0;
    while (wait_cnt != 9 && n < 500) begin
      step();
      n++;
    end
    chk("midmac_reached", {31'd0, wait_cnt == 9}, 32'd1);
    do_reset();
    for (int i = 0; i < 60; i++) step();
    run_scn(0, 1'b0);

    // Random data with random stalls on both sides, model-checked.
    do_reset();
    mode = 3;
    for (int i = 0; i < 200; i++) src_q.push_back(int'($urandom));
    set_inputs();
    drain("random");
    chk("random_count", got_q.size(), 32'd25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
